// File: rtl/ref_level_ctrl.sv
// Window sequencer and reference-level estimator for the 4-PAM slicer datapath.
// Define REF_LEVEL_IIR_EN to make ref_level track new estimates through a first-order IIR.
module ref_level_ctrl #(
  parameter int          WIN_LOG2    = 10,
  parameter int          SETTLE_SYMS = 64,
  parameter int          LATCH_DLY   = 2,
  parameter logic [17:0] LOCK_TOL    = 18'd512,
  parameter int          LOCK_COUNT  = 4,
  parameter int          IIR_SHIFT   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 en,
  input  logic [17+WIN_LOG2:0] acc_in,
  output logic                 acc_clear,
  output logic                 acc_en,
  output logic [17:0]          ref_level,
  output logic [17:0]          level_inner,
  output logic [17:0]          level_outer,
  output logic                 ref_valid,
  output logic                 locked,
  output logic                 window_done,
  output logic [2:0]           state
);

  localparam int WIN_SYMS = 1 << WIN_LOG2;
  localparam int CNT_MAX  = (SETTLE_SYMS > WIN_SYMS) ? SETTLE_SYMS : WIN_SYMS;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int LAT_W    = $clog2(LATCH_DLY + 1);
  localparam int MCH_W    = $clog2(LOCK_COUNT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    CLEAR  = 3'd2,
    WINDOW = 3'd3,
    LATCH  = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] sym_cnt_reg, sym_cnt_next;
  logic [LAT_W-1:0] lat_cnt_reg, lat_cnt_next;
  logic [MCH_W-1:0] match_cnt_reg, match_inc;
  logic [17:0]      ref_level_reg, level_inner_reg, level_outer_reg;
  logic             ref_valid_reg, locked_reg, window_done_reg;
  logic             capture;

  // en gates everything combinationally so strobes stop in the same clk it falls.
  always_comb begin
    state_next   = state_reg;
    sym_cnt_next = sym_cnt_reg;
    lat_cnt_next = '0;
    capture      = 1'b0;
    acc_clear    = 1'b0;
    acc_en       = 1'b0;
    if (!en) begin
      state_next   = IDLE;
      sym_cnt_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next   = SETTLE;
          sym_cnt_next = '0;
        end
        SETTLE: begin
          if (SETTLE_SYMS == 0) begin
            state_next   = CLEAR;
            sym_cnt_next = '0;
          end else if (clk_en) begin
            if (sym_cnt_reg == CNT_W'(SETTLE_SYMS - 1)) begin
              state_next   = CLEAR;
              sym_cnt_next = '0;
            end else begin
              sym_cnt_next = sym_cnt_reg + 1'b1;
            end
          end
        end
        CLEAR: begin
          acc_clear    = 1'b1;
          state_next   = WINDOW;
          sym_cnt_next = '0;
        end
        WINDOW: begin
          acc_en = clk_en;
          if (clk_en) begin
            if (sym_cnt_reg == CNT_W'(WIN_SYMS - 1)) begin
              state_next   = LATCH;
              sym_cnt_next = '0;
            end else begin
              sym_cnt_next = sym_cnt_reg + 1'b1;
            end
          end
        end
        LATCH: begin
          if (lat_cnt_reg == LAT_W'(LATCH_DLY - 1)) begin
            capture    = 1'b1;
            state_next = CLEAR;
          end else begin
            lat_cnt_next = lat_cnt_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Levels are non-negative magnitudes, so differences are formed on zero-extended operands.
  logic [17:0]        new_level, tracked_level;
  logic signed [18:0] delta;
  logic [18:0]        diff, outer_sum;
  logic               match;
  logic               unused_acc_lsb;

  assign new_level      = acc_in[17+WIN_LOG2:WIN_LOG2];
  assign unused_acc_lsb = ^acc_in[WIN_LOG2-1:0];
  assign delta          = $signed({1'b0, new_level}) - $signed({1'b0, ref_level_reg});
  assign diff           = delta[18] ? $unsigned(-delta) : $unsigned(delta);
  assign match          = (diff <= {1'b0, LOCK_TOL});
  assign match_inc      = (match_cnt_reg == MCH_W'(LOCK_COUNT)) ? match_cnt_reg : match_cnt_reg + 1'b1;
  assign outer_sum      = {1'b0, ref_level_reg} + {2'b00, ref_level_reg[17:1]};

`ifdef REF_LEVEL_IIR_EN
  logic signed [18:0] iir_step;
  logic [18:0]        iir_sum;
  logic               unused_iir_msb;
  assign iir_step       = delta >>> IIR_SHIFT;
  assign iir_sum        = {1'b0, ref_level_reg} + $unsigned(iir_step);
  assign tracked_level  = iir_sum[17:0];
  assign unused_iir_msb = iir_sum[18];
`else
  logic [31:0] unused_iir_shift;
  assign tracked_level    = new_level;
  assign unused_iir_shift = 32'(IIR_SHIFT);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      sym_cnt_reg     <= '0;
      lat_cnt_reg     <= '0;
      match_cnt_reg   <= '0;
      ref_level_reg   <= '0;
      level_inner_reg <= '0;
      level_outer_reg <= '0;
      ref_valid_reg   <= 1'b0;
      locked_reg      <= 1'b0;
      window_done_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sym_cnt_reg     <= sym_cnt_next;
      lat_cnt_reg     <= lat_cnt_next;
      window_done_reg <= capture;
      if (!en) begin
        match_cnt_reg <= '0;
        ref_valid_reg <= 1'b0;
        locked_reg    <= 1'b0;
      end else if (capture) begin
        if (!ref_valid_reg) begin
          ref_level_reg <= new_level;
          match_cnt_reg <= '0;
          locked_reg    <= 1'b0;
          ref_valid_reg <= 1'b1;
        end else begin
          ref_level_reg <= tracked_level;
          if (match) begin
            match_cnt_reg <= match_inc;
            if (match_inc == MCH_W'(LOCK_COUNT)) locked_reg <= 1'b1;
          end else begin
            match_cnt_reg <= '0;
            locked_reg    <= 1'b0;
          end
        end
      end
      level_inner_reg <= {1'b0, ref_level_reg[17:1]};
      level_outer_reg <= (outer_sum > 19'h1FFFF) ? 18'h1FFFF : outer_sum[17:0];
    end
  end

  assign ref_level   = ref_level_reg;
  assign level_inner = level_inner_reg;
  assign level_outer = level_outer_reg;
  assign ref_valid   = ref_valid_reg;
  assign locked      = locked_reg;
  assign window_done = window_done_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_ref_level_ctrl.sv
// Scoreboard bench for ref_level_ctrl: randomized window sums fed through a modelled
// two-stage external accumulator, expected captures queued and checked on window_done.
`timescale 1ns/1ps
module tb_ref_level_ctrl;

  localparam int WIN    = 16;
  localparam int ACC_W  = 22;
  localparam int TOL    = 512;
  localparam int LCOUNT = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clk_en = 1'b0;
  logic              en = 1'b0;
  logic [ACC_W-1:0]  acc_in;
  logic              acc_clear, acc_en, ref_valid, locked, window_done;
  logic [17:0]       ref_level, level_inner, level_outer;
  logic [2:0]        state;

  ref_level_ctrl #(
    .WIN_LOG2(4), .SETTLE_SYMS(8), .LATCH_DLY(2),
    .LOCK_TOL(18'd512), .LOCK_COUNT(4), .IIR_SHIFT(3)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .en(en), .acc_in(acc_in),
    .acc_clear(acc_clear), .acc_en(acc_en), .ref_level(ref_level),
    .level_inner(level_inner), .level_outer(level_outer), .ref_valid(ref_valid),
    .locked(locked), .window_done(window_done), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Symbol strobe on every 4th clk.
  int unsigned cyc = 0;
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    clk_en = (cyc % 4 == 0);
  end

  // External accumulator: one register stage on the gated sample, then the sum.
  logic [ACC_W-1:0] acc = '0, samp_d = '0;
  logic             en_d = 1'b0, first_sym = 1'b0, force_max = 1'b0;
  int unsigned      samp_base = 0, samp_extra = 0;
  always @(posedge clk) begin
    if (reset) begin
      acc <= '0; samp_d <= '0; en_d <= 1'b0; first_sym <= 1'b0;
    end else begin
      en_d   <= acc_en;
      samp_d <= ACC_W'(samp_base + (first_sym ? samp_extra : 0));
      if (acc_clear) begin
        acc       <= '0;
        first_sym <= 1'b1;
      end else begin
        if (en_d) acc <= acc + samp_d;
        if (acc_en) first_sym <= 1'b0;
      end
    end
  end
  assign acc_in = force_max ? {ACC_W{1'b1}} : acc;

  // Reference model: plain integer arithmetic on captured window means.
  typedef struct { int unsigned ref_lv; int unsigned inner; int unsigned outer; bit lock; } exp_t;
  exp_t        exp_q[$];
  int unsigned m_ref = 0, m_streak = 0;
  bit          m_valid = 0, m_lock = 0;

  function automatic void model_capture(input int unsigned nv);
    exp_t e;
    int   d;
    if (!m_valid) begin
      m_ref = nv; m_streak = 0; m_lock = 0; m_valid = 1;
    end else begin
      d = int'(nv) - int'(m_ref);
      if ((d < 0 ? -d : d) <= TOL) begin
        if (m_streak < LCOUNT) m_streak++;
        m_lock = (m_streak == LCOUNT);
      end else begin
        m_streak = 0; m_lock = 0;
      end
`ifdef REF_LEVEL_IIR_EN
      m_ref = int'(m_ref) + (d >>> 3);
`else
      m_ref = nv;
`endif
    end
    e.ref_lv = m_ref;
    e.inner  = m_ref / 2;
    e.outer  = (m_ref + m_ref / 2 > 131071) ? 131071 : m_ref + m_ref / 2;
    e.lock   = m_lock;
    exp_q.push_back(e);
  endfunction

  function automatic void model_disable();
    m_valid = 0; m_streak = 0; m_lock = 0;
  endfunction

  // Monitor: pop one expectation per window_done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (window_done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_window_done: got pulse, required no capture");
        end else begin
          e = exp_q.pop_front();
          chk("ref_level", ref_level, e.ref_lv);
          chk("locked", locked, e.lock);
          chk("ref_valid", ref_valid, 1);
          $display("capture: ref_level=%0d locked=%0d expected %0d/%0d", ref_level, locked, e.ref_lv, e.lock);
          @(negedge clk);
          chk("level_inner", level_inner, e.inner);
          chk("level_outer", level_outer, e.outer);
          chk("window_done_width", window_done, 0);
        end
      end
    end
  end

  task automatic enable_aligned();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = clk_en;
    end
    @(posedge clk);
    #1 en = 1'b1;
  endtask

  task automatic wait_clear(input int exp_pre, output bit seen);
    int pre = 0, stray = 0;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (acc_clear) seen = 1;
      else begin
        if (clk_en) pre++;
        if (acc_en) stray++;
      end
    end
    chk("acc_clear_seen", seen, 1);
    chk("acc_en_outside_window", stray, 0);
    if (exp_pre >= 0) chk("settle_pulses", pre, exp_pre);
  endtask

  task automatic run_window(input int unsigned v, input int unsigned r, input bit fmax, input int exp_pre);
    bit          seen;
    int          n;
    int unsigned nv;
    wait_clear(exp_pre, seen);
    if (!seen) return;
    samp_base = v; samp_extra = r; force_max = fmax;
    @(negedge clk);
    chk("acc_clear_width", acc_clear, 0);
    n = acc_en ? 1 : 0;
    for (int i = 0; i < 300 && n < WIN; i++) begin
      @(negedge clk);
      if (acc_en) n++;
    end
    chk("acc_en_pulses", n, WIN);
    nv = fmax ? ((1 << ACC_W) - 1) / WIN : (WIN * v + r) / WIN;
    model_capture(nv);
    $display("window: sample=%0d extra=%0d max=%0d -> expect new=%0d", v, r, fmax, nv);
  endtask

  task automatic abort_window(input int unsigned v);
    bit seen;
    int n = 0;
    wait_clear(-1, seen);
    samp_base = v; samp_extra = 0; force_max = 1'b0;
    for (int i = 0; i < 300 && n < 7; i++) begin
      @(negedge clk);
      if (acc_en) n++;
    end
    chk("abort_pre_pulses", n, 7);
    repeat (4) @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    chk("abort_acc_en_gated", acc_en, 0);
    chk("abort_state_same_clk", state, 3);
    model_disable();
    @(negedge clk);
    chk("abort_state_idle", state, 0);
    chk("abort_ref_valid", ref_valid, 0);
    chk("abort_locked", locked, 0);
    chk("abort_ref_hold", ref_level, m_ref);
    repeat (5) @(negedge clk);
    chk("idle_ref_hold", ref_level, m_ref);
    chk("idle_inner_hold", level_inner, m_ref / 2);
    chk("idle_outer_hold", level_outer, m_ref + m_ref / 2);
    chk("idle_acc_clear", acc_clear, 0);
    $display("abort: state=%0d ref_level=%0d ref_valid=%0d", state, ref_level, ref_valid);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_ref_level", ref_level, 0);
    chk("rst_level_inner", level_inner, 0);
    chk("rst_level_outer", level_outer, 0);
    chk("rst_ref_valid", ref_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_window_done", window_done, 0);
    chk("rst_acc_en", acc_en, 0);
    chk("rst_acc_clear", acc_clear, 0);
    chk("rst_state", state, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_state", state, 0);
    chk("idle_no_clear", acc_clear, 0);

    enable_aligned();
    run_window(20000, 0, 0, 8);
    run_window(20000, $urandom_range(0, 15), 0, -1);
    run_window(20100, $urandom_range(0, 15), 0, -1);
    run_window(19900, $urandom_range(0, 15), 0, -1);
    run_window(20300, $urandom_range(0, 15), 0, -1);
    run_window(21000, $urandom_range(0, 15), 0, -1);
    abort_window(30000);

    enable_aligned();
    run_window(0, 0, 1, 8);

    base = 20000;
    for (int w = 0; w < 20; w++) begin
      if (w % 6 == 0) base = $urandom_range(5000, 200000);
      run_window(base + $urandom_range(0, 700), $urandom_range(0, 15), 0, -1);
    end

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
